// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and frame constants, reusable by a future receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_tx_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_STOP_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_counter.sv
// Per-bit cycle counter: bit_done pulses on the last cycle of each serial bit.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_done
);

    logic [15:0] r_cnt;

    assign bit_done = (r_cnt == 16'(CLKS_PER_BIT - 1));

    // Wraps on its own at the end of every bit so consecutive bits need no clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (clear || bit_done)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 16'd1;
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 frames, or 8E1 when UART_TX_PARITY_EN is defined.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cpu_to_uart_buf,
    input  logic       cpu_start_write,
    output logic       uart_out,
    output logic       write_busy,
    output logic       write_int
);

    uart_tx_state_t r_state, w_state_nx;
    logic [7:0]     r_shift, w_shift_nx;
    logic [2:0]     r_idx,   w_idx_nx;
    logic           r_out,   w_out_nx;
    logic           r_int,   w_int_nx;
    logic           w_bit_done;
    logic           w_clear;
`ifdef UART_TX_PARITY_EN
    logic           r_parity, w_parity_nx;
`endif

    uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_clear),
        .bit_done (w_bit_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_out   <= UART_STOP_LEVEL;
            r_int   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_shift <= w_shift_nx;
            r_idx   <= w_idx_nx;
            r_out   <= w_out_nx;
            r_int   <= w_int_nx;
`ifdef UART_TX_PARITY_EN
            r_parity <= w_parity_nx;
`endif
        end
    end

    // The line value for the next bit is computed one cycle ahead so uart_out stays a flop.
    always_comb begin
        w_state_nx = r_state;
        w_shift_nx = r_shift;
        w_idx_nx   = r_idx;
        w_out_nx   = r_out;
        w_int_nx   = 1'b0;
        w_clear    = (r_state == ST_IDLE);
`ifdef UART_TX_PARITY_EN
        w_parity_nx = r_parity;
`endif
        case (r_state)
            ST_IDLE: begin
                w_out_nx = UART_STOP_LEVEL;
                if (cpu_start_write) begin
                    w_state_nx = ST_START;
                    w_shift_nx = cpu_to_uart_buf;
                    w_idx_nx   = '0;
                    w_out_nx   = 1'b0;
`ifdef UART_TX_PARITY_EN
                    w_parity_nx = ^cpu_to_uart_buf;
`endif
                end
            end
            ST_START: begin
                if (w_bit_done) begin
                    w_state_nx = ST_DATA;
                    w_out_nx   = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_bit_done) begin
                    w_shift_nx = r_shift >> 1;
                    if (r_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nx = ST_PARITY;
                        w_out_nx   = r_parity;
`else
                        w_state_nx = ST_STOP;
                        w_out_nx   = UART_STOP_LEVEL;
`endif
                    end else begin
                        w_idx_nx = r_idx + 3'd1;
                        w_out_nx = r_shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_bit_done) begin
                    w_state_nx = ST_STOP;
                    w_out_nx   = UART_STOP_LEVEL;
                end
            end
`endif
            ST_STOP: begin
                if (w_bit_done) begin
                    w_state_nx = ST_IDLE;
                    w_out_nx   = UART_STOP_LEVEL;
                    w_int_nx   = 1'b1;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_out_nx   = UART_STOP_LEVEL;
            end
        endcase
    end

    assign uart_out   = r_out;
    assign write_int  = r_int;
    assign write_busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at CLKS_PER_BIT=10 and 2; frame-level model plus directed literal checks.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       st [2];
    logic [7:0] bf [2];
    logic       uo [2];
    logic       wb [2];
    logic       wi [2];

    int cpb [2] = '{10, 2};
    int n_checks = 0;
    int n_errors = 0;
    int nint [2] = '{0, 0};

    // Model state: cycles since the accepting edge (cycle 1 is right after it).
    logic       m_act [2] = '{1'b0, 1'b0};
    int         m_t   [2] = '{0, 0};
    logic [7:0] m_d   [2];

    logic ln [1:300];
    logic iv [1:300];

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(10)) dut10 (
        .clk(clk), .rst(rst), .cpu_to_uart_buf(bf[0]), .cpu_start_write(st[0]),
        .uart_out(uo[0]), .write_busy(wb[0]), .write_int(wi[0])
    );

    uart_tx #(.CLKS_PER_BIT(2)) dut2 (
        .clk(clk), .rst(rst), .cpu_to_uart_buf(bf[1]), .cpu_start_write(st[1]),
        .uart_out(uo[1]), .write_busy(wb[1]), .write_int(wi[1])
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (FB == 11 && k == 9) return ($countones(d) % 2) == 1;
        return 1'b1;
    endfunction

    // Frame-level model: a frame occupies FB*CLKS cycles, then one write_int cycle in which
    // the transmitter is already idle and may accept again.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    m_act[d] = 1'b0;
                    m_t[d]   = 0;
                end else if (clk) begin
                    if ((!m_act[d] || m_t[d] >= FB * cpb[d]) && st[d]) begin
                        m_act[d] = 1'b1;
                        m_t[d]   = 0;
                        m_d[d]   = bf[d];
                    end else if (m_act[d]) begin
                        m_t[d] = m_t[d] + 1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                logic in_frame;
                logic e_out;
                in_frame = m_act[d] && (m_t[d] < FB * cpb[d]);
                e_out    = in_frame ? frame_bit(m_d[d], m_t[d] / cpb[d]) : 1'b1;
                chk($sformatf("model_out[%0d]", d), int'(uo[d]), int'(e_out));
                chk($sformatf("model_busy[%0d]", d), int'(wb[d]), int'(in_frame));
                chk($sformatf("model_int[%0d]", d), int'(wi[d]),
                    int'(m_act[d] && m_t[d] == FB * cpb[d]));
                if (wi[d]) nint[d]++;
            end
        end
    end

    // Called at a negedge: request one start, return at the negedge of cycle 1.
    task automatic pulse_start(input int d, input logic [7:0] v);
        bf[d] = v;
        st[d] = 1'b1;
        @(negedge clk);
        st[d] = 1'b0;
    endtask

    task automatic wait_int(input int d, input int c0, output int cyc);
        cyc = c0;
        while (!wi[d] && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        if (!wi[d]) chk("wait_int_timeout", 0, 1);
    endtask

    task automatic capture(input int d, input int ncyc);
        for (int c = 1; c <= ncyc; c++) begin
            ln[c] = uo[d];
            iv[c] = wi[d];
            if (c < ncyc) @(negedge clk);
        end
    endtask

    initial begin
        int cyc;
        int n0;
        int lows;
`ifdef UART_TX_PARITY_EN
        int a5_bits [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
        int a5_bits [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif
        for (int d = 0; d < 2; d++) begin
            st[d] = 1'b0;
            bf[d] = 8'h00;
        end

        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_out", int'(uo[d]), 1);
            chk("reset_busy", int'(wb[d]), 0);
            chk("reset_int", int'(wi[d]), 0);
        end
        rst = 1'b0;
        @(negedge clk);

        // 0xA5 waveform, bit by bit, and write_int in cycle FB*10+1
        pulse_start(0, 8'hA5);
        capture(0, FB * 10 + 1);
        for (int k = 0; k < FB; k++)
            for (int c = 1; c <= 10; c++)
                chk($sformatf("a5_bit%0d", k), int'(ln[k*10 + c]), a5_bits[k]);
        chk("a5_int_cycle", int'(iv[FB*10+1]), 1);
        chk("a5_int_early", int'(iv[FB*10]), 0);
        repeat (3) @(negedge clk);

        // second request mid-frame is dropped
        n0 = nint[0];
        pulse_start(0, 8'h3C);
        repeat (29) @(negedge clk);
        pulse_start(0, 8'hFF);
        wait_int(0, 31, cyc);
        chk("3c_int_cycle", cyc, FB * 10 + 1);
        repeat (150) @(negedge clk);
        chk("3c_one_int", nint[0] - n0, 1);

        // start in the write_int cycle: one idle-high cycle then the next frame
        pulse_start(0, 8'h01);
        wait_int(0, 1, cyc);
        chk("b2b_first_int", cyc, FB * 10 + 1);
        chk("b2b_gap_high", int'(uo[0]), 1);
        pulse_start(0, 8'h80);
        chk("b2b_start_low", int'(uo[0]), 0);
        wait_int(0, 1, cyc);
        chk("b2b_int_spacing", cyc, FB * 10 + 1);
        repeat (3) @(negedge clk);

        // async reset mid-frame, then accept on the first edge after release
        pulse_start(0, 8'h55);
        repeat (44) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_out", int'(uo[0]), 1);
        chk("rst_async_busy", int'(wb[0]), 0);
        chk("rst_async_int", int'(wi[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        n0 = nint[0];
        pulse_start(0, 8'h0F);
        wait_int(0, 1, cyc);
        chk("rst_0f_int_cycle", cyc, FB * 10 + 1);
        repeat (2) @(negedge clk);
        chk("rst_no_stale_int", nint[0] - n0, 1);

`ifdef UART_TX_PARITY_EN
        pulse_start(0, 8'h07);
        capture(0, 111);
        chk("par_07", int'(ln[95]), 1);
        chk("par_07_int", int'(iv[111]), 1);
        @(negedge clk);
        pulse_start(0, 8'h03);
        capture(0, 111);
        chk("par_03", int'(ln[95]), 0);
        chk("par_03_int", int'(iv[111]), 1);
        @(negedge clk);
`endif

        // CLKS_PER_BIT=2 with 0x00: start + data (+ parity 0) low, then 2 stop cycles
        pulse_start(1, 8'h00);
        capture(1, FB * 2 + 1);
        lows = 0;
        while (lows < FB * 2 && ln[lows+1] == 1'b0) lows++;
        chk("c2_low_cycles", lows, (FB - 1) * 2);
        chk("c2_stop_a", int'(ln[FB*2-1]), 1);
        chk("c2_stop_b", int'(ln[FB*2]), 1);
        chk("c2_int_cycle", int'(iv[FB*2+1]), 1);
        repeat (3) @(negedge clk);

        // start held high: one frame per accept, back to back
        n0 = nint[1];
        bf[1] = 8'h96;
        st[1] = 1'b1;
        repeat (70) @(negedge clk);
        st[1] = 1'b0;
        repeat (30) @(negedge clk);
        chk("held_frames", nint[1] - n0, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
